// File: rtl/lmfe_pkg.sv
// Shared definitions for the LMFE rank sorter: op encodings, slot mux selects,
// pad value and the standard window sizes.
package lmfe_pkg;

  localparam logic [1:0] OP_NOP = 2'b00;
  localparam logic [1:0] OP_INS = 2'b01;
  localparam logic [1:0] OP_REP = 2'b10;
  localparam logic [1:0] OP_DEL = 2'b11;

  localparam int unsigned W3 = 9;
  localparam int unsigned W5 = 25;
  localparam int unsigned W7 = 49;

  typedef enum logic [2:0] {
    SelSelf,
    SelPrev,
    SelNext,
    SelIns,
    SelPad
  } sel_e;

  // All-ones pixel of the given width; empty slots hold it so they sort last.
  function automatic logic [63:0] pad_value(input int unsigned dw);
    pad_value = (64'd1 << dw) - 64'd1;
  endfunction

endpackage

// File: rtl/lmfe_rank_cell.sv
// One slot of the sorted window: holds a pixel and loads it from a neighbour,
// the incoming pixel, the pad value, or keeps its own value.
module lmfe_rank_cell
  import lmfe_pkg::*;
#(
  parameter int unsigned DW = 8
) (
  input  logic          clk,
  input  logic          rst_n,
  input  sel_e          i_sel,
  input  logic [DW-1:0] i_prev,
  input  logic [DW-1:0] i_next,
  input  logic [DW-1:0] i_ins,
  output logic [DW-1:0] o_val
);

  localparam logic [DW-1:0] Pad = DW'(pad_value(DW));

  logic [DW-1:0] r_val;
  logic [DW-1:0] w_val_d;

  always_comb begin
    w_val_d = r_val;
    case (i_sel)
      SelPrev: w_val_d = i_prev;
      SelNext: w_val_d = i_next;
      SelIns:  w_val_d = i_ins;
      SelPad:  w_val_d = Pad;
      default: w_val_d = r_val;
    endcase
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_val <= Pad;
    end else begin
      r_val <= w_val_d;
    end
  end

  assign o_val = r_val;

endmodule

// File: rtl/lmfe_rank_sorter.sv
// Running ascending-sorted window of N pixels with insert/delete/replace and a
// selectable-rank readout. Ops are registered, applied one edge later, read out the next.
module lmfe_rank_sorter
  import lmfe_pkg::*;
#(
  parameter int unsigned N  = 49,
  parameter int unsigned DW = 8,
  parameter int unsigned RW = $clog2(N)
) (
  input  logic          clk,
  input  logic          RST_N,
  input  logic          CLR,
  input  logic          SEN,
  input  logic [1:0]    OP,
  input  logic [DW-1:0] INS,
  input  logic [DW-1:0] DEL,
  input  logic [RW-1:0] RANK,
  output logic [DW-1:0] RES,
  output logic          VAL,
  output logic [RW:0]   CNT,
  output logic          FULL,
  output logic          ERR
);

  localparam logic [DW-1:0] Pad  = DW'(pad_value(DW));
  localparam logic [RW:0]   NCnt = (RW+1)'(N);

  logic          r_op_vld;
  logic [1:0]    r_op;
  logic [DW-1:0] r_ins;
  logic [DW-1:0] r_del;
  logic [RW-1:0] r_rank;
  logic [RW:0]   r_cnt;
  logic [RW:0]   w_cnt_d;
  logic          r_s2_vld;
  logic          r_s2_err;
  logic [RW-1:0] r_s2_rank;

  logic [DW-1:0] w_slot [N];
  logic [N-1:0]  w_live;
  logic [N-1:0]  w_gt_ins;
  logic [N:0]    w_ins_ge;
  logic [N-1:0]  w_ins_eq;
  logic [N-1:0]  w_ins_last;
  logic [N-1:0]  w_del_raw;
  logic [N-1:0]  w_eq_del;
  logic [N-1:0]  w_del_ge;
  logic [N-1:0]  w_del_gt;
  logic          w_full, w_hit, w_up, w_err;
  logic          w_is_ins, w_is_del, w_is_rep;
  logic          w_do_ins, w_do_del, w_do_rep;
  logic [DW-1:0] w_rd;

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_op_vld <= 1'b0;
      r_op     <= OP_NOP;
      r_ins    <= '0;
      r_del    <= '0;
      r_rank   <= '0;
    end else begin
      r_op_vld <= SEN & ~CLR;
      if (SEN && !CLR) begin
        r_op   <= OP;
        r_ins  <= INS;
        r_del  <= DEL;
        r_rank <= RANK;
      end
    end
  end

  // Slots at or beyond CNT count as "greater than INS" so inserts land at CNT at the latest.
  for (genvar i = 0; i < N; i++) begin : g_cmp
    localparam logic [RW:0] Idx = (RW+1)'(i);
    assign w_live[i]    = Idx < r_cnt;
    assign w_gt_ins[i]  = w_slot[i] > r_ins;
    assign w_ins_ge[i]  = w_gt_ins[i] | ~w_live[i];
    assign w_del_raw[i] = w_live[i] & (w_slot[i] == r_del);
  end
  assign w_ins_ge[N] = 1'b1;

  always_comb begin
    logic v_any;
    v_any    = 1'b0;
    w_eq_del = '0;
    w_del_ge = '0;
    for (int i = 0; i < N; i++) begin
      w_eq_del[i] = w_del_raw[i] & ~v_any;
      v_any       = v_any | w_del_raw[i];
      w_del_ge[i] = v_any;
    end
  end

  assign w_ins_eq   = w_ins_ge[N-1:0] & ~{w_ins_ge[N-2:0], 1'b0};
  assign w_ins_last = w_ins_ge[N:1] & ~w_ins_ge[N-1:0];
  assign w_del_gt   = w_del_ge & ~w_eq_del;

  assign w_full   = (r_cnt == NCnt);
  assign w_hit    = |w_eq_del;
  assign w_is_ins = r_op_vld && (r_op == OP_INS);
  assign w_is_del = r_op_vld && (r_op == OP_DEL);
  assign w_is_rep = r_op_vld && (r_op == OP_REP);
  assign w_do_ins = w_is_ins & ~w_full;
  assign w_do_del = w_is_del & w_hit;
  assign w_do_rep = w_is_rep & w_hit;
  assign w_err    = (w_is_ins & w_full) | ((w_is_del | w_is_rep) & ~w_hit);
  // Insert point at or below the deleted slot: the gap opens upward, otherwise downward.
  assign w_up     = |(w_eq_del & w_ins_ge[N-1:0]);

  for (genvar i = 0; i < N; i++) begin : g_slot
    logic [DW-1:0] w_prev;
    logic [DW-1:0] w_next;
    sel_e          w_sel;

    if (i == 0) begin : g_first
      assign w_prev = Pad;
    end else begin : g_inner_lo
      assign w_prev = w_slot[i-1];
    end

    if (i == N - 1) begin : g_last
      assign w_next = Pad;
    end else begin : g_inner_hi
      assign w_next = w_slot[i+1];
    end

    always_comb begin
      w_sel = SelSelf;
      if (CLR) begin
        w_sel = SelPad;
      end else if (w_do_ins) begin
        if (w_ins_eq[i])      w_sel = SelIns;
        else if (w_ins_ge[i]) w_sel = SelPrev;
      end else if (w_do_del) begin
        if (w_del_ge[i]) w_sel = SelNext;
      end else if (w_do_rep) begin
        if (w_up) begin
          if (w_ins_eq[i])                     w_sel = SelIns;
          else if (w_ins_ge[i] && !w_del_gt[i]) w_sel = SelPrev;
        end else begin
          if (w_ins_last[i])                   w_sel = SelIns;
          else if (w_del_ge[i] && !w_ins_ge[i]) w_sel = SelNext;
        end
      end
    end

    lmfe_rank_cell #(
      .DW(DW)
    ) u_cell (
      .clk   (clk),
      .rst_n (RST_N),
      .i_sel (w_sel),
      .i_prev(w_prev),
      .i_next(w_next),
      .i_ins (r_ins),
      .o_val (w_slot[i])
    );
  end

  always_comb begin
    w_cnt_d = r_cnt;
    if (CLR)           w_cnt_d = '0;
    else if (w_do_ins) w_cnt_d = r_cnt + (RW+1)'(1);
    else if (w_do_del) w_cnt_d = r_cnt - (RW+1)'(1);
  end

  always_comb begin
    w_rd = Pad;
    for (int i = 0; i < N; i++) begin
      if (r_s2_rank == RW'(i)) w_rd = w_slot[i];
    end
  end

  always_ff @(posedge clk or negedge RST_N) begin
    if (!RST_N) begin
      r_cnt     <= '0;
      r_s2_vld  <= 1'b0;
      r_s2_err  <= 1'b0;
      r_s2_rank <= '0;
      RES       <= '0;
      VAL       <= 1'b0;
      ERR       <= 1'b0;
    end else begin
      r_cnt     <= w_cnt_d;
      r_s2_vld  <= r_op_vld;
      r_s2_err  <= w_err;
      r_s2_rank <= r_rank;
      VAL       <= r_s2_vld;
      ERR       <= r_s2_err;
      if (r_s2_vld) RES <= w_rd;
    end
  end

  assign CNT  = r_cnt;
  assign FULL = w_full;

endmodule

// File: tb/tb_lmfe_rank_sorter.sv
// Scoreboard bench: a 49-entry sorter driven by directed ops and a 9-entry
// sorter driven by random replaces against a sorted-queue reference.
module tb_lmfe_rank_sorter;
  import lmfe_pkg::*;

  logic clk = 1'b0;
  always #5 clk = ~clk;
  logic rst_n;

  logic       clr_a, sen_a;
  logic [1:0] op_a;
  logic [7:0] ins_a, del_a, res_a;
  logic [5:0] rank_a;
  logic [6:0] cnt_a;
  logic       val_a, full_a, err_a;

  logic       clr_b, sen_b;
  logic [1:0] op_b;
  logic [7:0] ins_b, del_b, res_b;
  logic [3:0] rank_b;
  logic [4:0] cnt_b;
  logic       val_b, full_b, err_b;

  lmfe_rank_sorter #(.N(49), .DW(8)) u_dut_a (
    .clk(clk), .RST_N(rst_n), .CLR(clr_a), .SEN(sen_a), .OP(op_a), .INS(ins_a),
    .DEL(del_a), .RANK(rank_a), .RES(res_a), .VAL(val_a), .CNT(cnt_a), .FULL(full_a),
    .ERR(err_a)
  );

  lmfe_rank_sorter #(.N(9), .DW(8)) u_dut_b (
    .clk(clk), .RST_N(rst_n), .CLR(clr_b), .SEN(sen_b), .OP(op_b), .INS(ins_b),
    .DEL(del_b), .RANK(rank_b), .RES(res_b), .VAL(val_b), .CNT(cnt_b), .FULL(full_b),
    .ERR(err_b)
  );

  typedef struct {
    int res;
    bit err;
  } exp_t;

  exp_t q_a[$];
  exp_t q_b[$];
  exp_t e_a, e_b;
  int   m[$];
  int   checks = 0;
  int   failures = 0;

  task automatic chk(input string name, input int act, input int exp);
    checks++;
    if (act != exp) begin
      failures++;
      $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
    end
  endtask

  always @(negedge clk) begin
    if (rst_n) begin
      if (val_a) begin
        if (q_a.size() == 0) begin
          chk("a_unexpected_val", 1, 0);
        end else begin
          e_a = q_a.pop_front();
          chk("a_res", int'(res_a), e_a.res);
          chk("a_err", int'(err_a), int'(e_a.err));
        end
      end else if (err_a) begin
        chk("a_err_without_val", 1, 0);
      end
    end
  end

  always @(negedge clk) begin
    if (rst_n) begin
      if (val_b) begin
        if (q_b.size() == 0) begin
          chk("b_unexpected_val", 1, 0);
        end else begin
          e_b = q_b.pop_front();
          chk("b_res", int'(res_b), e_b.res);
          chk("b_err", int'(err_b), int'(e_b.err));
        end
      end else if (err_b) begin
        chk("b_err_without_val", 1, 0);
      end
    end
  end

  task automatic idle(input int n);
    repeat (n) begin
      @(posedge clk);
      #1;
    end
  endtask

  task automatic issue_a(input logic [1:0] op, input int ins, input int del, input int rank,
                         input int exp_res, input bit exp_err);
    exp_t e;
    sen_a = 1'b1; op_a = op; ins_a = 8'(ins); del_a = 8'(del); rank_a = 6'(rank);
    e.res = exp_res; e.err = exp_err;
    q_a.push_back(e);
    @(posedge clk);
    #1;
    sen_a = 1'b0;
  endtask

  task automatic issue_b(input logic [1:0] op, input int ins, input int del, input int rank,
                         input int exp_res, input bit exp_err);
    exp_t e;
    sen_b = 1'b1; op_b = op; ins_b = 8'(ins); del_b = 8'(del); rank_b = 4'(rank);
    e.res = exp_res; e.err = exp_err;
    q_b.push_back(e);
    @(posedge clk);
    #1;
    sen_b = 1'b0;
  endtask

  // Erroring op issued with nothing in flight: ERR/VAL low one edge later, high two edges later.
  task automatic err_timed_a(input logic [1:0] op, input int ins, input int del, input int rank,
                             input int exp_res);
    issue_a(op, ins, del, rank, exp_res, 1'b1);
    @(posedge clk);
    #1;
    chk("err_t1_val", int'(val_a), 0);
    chk("err_t1_err", int'(err_a), 0);
    @(posedge clk);
    #1;
    chk("err_t2_val", int'(val_a), 1);
    chk("err_t2_err", int'(err_a), 1);
  endtask

  task automatic clr_sen_a(input logic sen);
    clr_a = 1'b1; sen_a = sen; op_a = OP_INS; ins_a = 8'd5; rank_a = 6'd0;
    @(posedge clk);
    #1;
    clr_a = 1'b0; sen_a = 1'b0;
  endtask

  function automatic void m_insert(input int v);
    int p;
    p = m.size();
    for (int k = 0; k < m.size(); k++) begin
      if (m[k] > v) begin
        p = k;
        break;
      end
    end
    m.insert(p, v);
  endfunction

  function automatic void m_delete(input int v);
    for (int k = 0; k < m.size(); k++) begin
      if (m[k] == v) begin
        m.delete(k);
        return;
      end
    end
  endfunction

  function automatic int m_rank(input int r);
    return (r < m.size()) ? m[r] : 255;
  endfunction

  initial begin
    #200000;
    $display("FAIL watchdog: got no finish, expected finish before time limit");
    $fatal(1);
  end

  initial begin
    int d, v;
    rst_n = 1'b1;
    clr_a = 0; sen_a = 0; op_a = OP_NOP; ins_a = 0; del_a = 0; rank_a = 0;
    clr_b = 0; sen_b = 0; op_b = OP_NOP; ins_b = 0; del_b = 0; rank_b = 0;
    #1 rst_n = 1'b0;
    #2;
    chk("rst_res", int'(res_a), 0);
    chk("rst_val", int'(val_a), 0);
    chk("rst_err", int'(err_a), 0);
    chk("rst_cnt", int'(cnt_a), 0);
    chk("rst_full", int'(full_a), 0);
    #9 rst_n = 1'b1;
    @(posedge clk);
    #1;

    // Fill with 48..0 descending, watching the rank-24 entry
    for (int k = 0; k < 49; k++) issue_a(OP_INS, 48 - k, 0, 24, (k >= 24) ? 72 - k : 255, 1'b0);
    idle(2);
    chk("fill_cnt", int'(cnt_a), 49);
    chk("fill_full", int'(full_a), 1);
    issue_a(OP_NOP, 0, 0, 0, 0, 1'b0);
    issue_a(OP_NOP, 0, 0, 48, 48, 1'b0);
    issue_a(OP_NOP, 0, 0, 63, 255, 1'b0);

    issue_a(OP_REP, 200, 10, 24, 25, 1'b0);
    issue_a(OP_NOP, 0, 0, 48, 200, 1'b0);
    issue_a(OP_NOP, 0, 0, 47, 48, 1'b0);
    issue_a(OP_NOP, 0, 0, 10, 11, 1'b0);
    idle(3);
    chk("rep_cnt", int'(cnt_a), 49);

    err_timed_a(OP_INS, 3, 0, 0, 0);
    chk("ins_full_cnt", int'(cnt_a), 49);
    issue_a(OP_REP, 1, 99, 48, 200, 1'b1);
    issue_a(OP_DEL, 0, 99, 48, 200, 1'b1);
    issue_a(OP_DEL, 0, 200, 48, 255, 1'b0);
    issue_a(OP_NOP, 0, 0, 47, 48, 1'b0);
    idle(2);
    chk("del_top_cnt", int'(cnt_a), 48);
    chk("del_top_full", int'(full_a), 0);
    issue_a(OP_INS, 10, 0, 10, 10, 1'b0);
    idle(2);
    chk("refill_cnt", int'(cnt_a), 49);

    // Clear with a simultaneous insert; the insert must vanish silently
    issue_a(OP_NOP, 0, 0, 5, 5, 1'b0);
    idle(1);
    clr_sen_a(1'b1);
    chk("clr_cnt", int'(cnt_a), 0);
    chk("clr_full", int'(full_a), 0);
    issue_a(OP_NOP, 0, 0, 0, 255, 1'b0);
    issue_a(OP_NOP, 0, 0, 48, 255, 1'b0);
    issue_a(OP_NOP, 0, 0, 63, 255, 1'b0);

    issue_a(OP_INS, 5, 0, 0, 5, 1'b0);
    issue_a(OP_INS, 5, 0, 1, 5, 1'b0);
    issue_a(OP_INS, 5, 0, 2, 5, 1'b0);
    issue_a(OP_INS, 7, 0, 3, 7, 1'b0);
    issue_a(OP_DEL, 0, 5, 2, 7, 1'b0);
    issue_a(OP_NOP, 0, 0, 0, 5, 1'b0);
    issue_a(OP_NOP, 0, 0, 1, 5, 1'b0);
    issue_a(OP_NOP, 0, 0, 3, 255, 1'b0);
    issue_a(OP_DEL, 0, 9, 2, 7, 1'b1);
    idle(2);
    chk("dup_cnt", int'(cnt_a), 3);
    issue_a(OP_REP, 5, 5, 1, 5, 1'b0);
    issue_a(OP_REP, 1, 7, 0, 1, 1'b0);
    issue_a(OP_NOP, 0, 0, 2, 5, 1'b0);
    issue_a(OP_REP, 9, 5, 2, 9, 1'b0);
    issue_a(OP_NOP, 0, 0, 1, 5, 1'b0);
    idle(2);
    chk("rep_dup_cnt", int'(cnt_a), 3);

    clr_sen_a(1'b0);
    idle(3);
    err_timed_a(OP_DEL, 0, 1, 0, 255);
    issue_a(OP_REP, 2, 1, 0, 255, 1'b1);
    idle(2);
    chk("empty_cnt", int'(cnt_a), 0);

    // Asynchronous reset in the middle of a burst
    issue_a(OP_INS, 10, 0, 0, 10, 1'b0);
    issue_a(OP_INS, 20, 0, 0, 10, 1'b0);
    issue_a(OP_INS, 30, 0, 0, 10, 1'b0);
    #2 rst_n = 1'b0;
    q_a.delete();
    #1;
    chk("mid_rst_res", int'(res_a), 0);
    chk("mid_rst_val", int'(val_a), 0);
    chk("mid_rst_err", int'(err_a), 0);
    chk("mid_rst_cnt", int'(cnt_a), 0);
    chk("mid_rst_full", int'(full_a), 0);
    #2 rst_n = 1'b1;
    @(posedge clk);
    #1;
    issue_a(OP_NOP, 0, 0, 0, 255, 1'b0);
    idle(3);

    // Nine-entry window: random fill then random replaces, median each time
    for (int k = 0; k < 9; k++) begin
      v = int'($urandom_range(0, 255));
      m_insert(v);
      issue_b(OP_INS, v, 0, 4, m_rank(4), 1'b0);
    end
    for (int k = 0; k < 100; k++) begin
      d = m[$urandom_range(0, 8)];
      v = int'($urandom_range(0, 255));
      m_delete(d);
      m_insert(v);
      issue_b(OP_REP, v, d, 4, m_rank(4), 1'b0);
    end
    issue_b(OP_INS, 0, 0, 8, m_rank(8), 1'b1);
    idle(2);
    chk("b_cnt", int'(cnt_b), 9);
    chk("b_full", int'(full_b), 1);

    for (int k = 0; k < 10; k++) begin
      if (q_a.size() != 0 || q_b.size() != 0) idle(1);
    end
    chk("drain_a", q_a.size(), 0);
    chk("drain_b", q_b.size(), 0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule

// File: doc/lmfe_rank_sorter.md
Name: lmfe_rank_sorter

Overview:
- Parametrised successor to the fixed 49-entry median sorter in the LMFE filter engine.
- Keeps a running, ascending-sorted window of N pixels and supports insert, delete and replace operations.
- Returns any selectable rank (min, median, max or arbitrary), not only the median.
- Sits between filter_ctrl and the output path; lets the engine run 3x3, 5x5 or 7x7 windows with one RTL.

Parameters:
- N, 49, window entry count (9, 25, 49 typical; legal range 2..64).
- DW, 8, pixel width in bits.
- RW, $clog2(N), width of the rank and count fields (derived; do not override).

Ports:
- clk  input  1  rising-edge clock.
- RST_N  input  1  asynchronous, active-low reset.
- CLR  input  1  synchronous clear of the window; priority over SEN.
- SEN  input  1  operation strobe; one op accepted per cycle.
- OP  input  2  operation: 00 NOP, 01 INSERT, 10 REPLACE (delete DEL, then insert INS), 11 DELETE.
- INS  input  DW  value to insert.
- DEL  input  DW  value to remove.
- RANK  input  RW  result index; 0 = minimum. Sampled with SEN.
- RES  output  DW  registered value of sorted[RANK].
- VAL  output  1  one-cycle pulse qualifying RES.
- CNT  output  RW+1  number of live entries.
- FULL  output  1  CNT == N.
- ERR  output  1  one-cycle pulse on an illegal or missed operation.

Behaviour:
- Storage:
  - N registers, sorted ascending.
  - Unused slots hold the pad value 2^DW-1, so live entries occupy indices 0..CNT-1.
  - A pixel equal to the pad value sorts stably among the pads; CNT alone defines liveness.
- Reset (RST_N low, asynchronous):
  - All slots become pad; CNT=0, FULL=0.
  - RES=0, VAL=0, ERR=0.
  - In-flight operations are discarded.
- Latency:
  - Op accepted at edge t (SEN=1, CLR=0).
  - Array and CNT update at edge t+1.
  - RES/VAL register at edge t+2 from the updated array, using the RANK sampled at t.
  - Full throughput: back-to-back ops every cycle.
- Per-slot update: each slot is computed in one cycle from its neighbours i-1, i, i+1, using two comparator vectors:
  - gt_ins[i] = slot[i] > INS
  - eq_del[i] = first slot with slot[i] == DEL, searching only indices below CNT.
- INSERT:
  - Allowed when CNT<N; INS goes before the first strictly greater entry (stable for duplicates); CNT+1.
  - If FULL: array unchanged, ERR pulse, VAL still pulses with RES from the unchanged array.
- DELETE:
  - Removes exactly one instance of DEL (the lowest index) and shifts higher entries down; pad enters at N-1; CNT-1.
  - No match (including CNT=0): array unchanged, ERR pulse.
- REPLACE:
  - Delete and insert happen in the same cycle; CNT unchanged.
  - Legal at any CNT>=1.
  - On a delete miss the whole op is suppressed (no insert) and ERR pulses.
  - INS==DEL is a legal no-change op.
- NOP with SEN=1: array unchanged; VAL pulses, so the bench can poll any rank.
- RANK>=CNT: RES returns the pad value 2^DW-1; this is not an error.
- CLR:
  - Next edge: all slots pad, CNT=0.
  - A SEN in the same cycle is dropped without ERR.
  - VAL/ERR scheduled from the prior cycle still emerge at their normal time.
- Median rank for an odd N window is (N-1)/2. The controller drives RANK; the sorter has no fixed median.
- Arithmetic: comparisons are unsigned, DW bits. CNT never wraps; guarded by the FULL and empty checks above.

Decomposition:
- Shared package lmfe_pkg holds:
  - OP encodings: OP_NOP, OP_INS, OP_REP, OP_DEL.
  - The pad constant as a function of DW.
  - Default window sizes: W3=9, W5=25, W7=49.
- Sub-module lmfe_rank_cell: one storage slot plus its neighbour-select mux (prev/self/next/INS/pad).
  - Instantiated N times by a generate loop.
  - The top keeps the comparator vectors, position encoding, CNT, error and output registers.

Test Plan:
- Reset, then INSERT 49 values 48..0 descending with RANK=24 → after the last insert CNT=49, FULL=1, RES=24 two cycles later; RANK=0 gives 0, RANK=48 gives 48.
- Full window 0..48, REPLACE DEL=10 INS=200 with RANK=24 → RES=25, RANK=48 gives 200, CNT=49, no ERR.
- Duplicates: INSERT 5,5,5,7, then DELETE 5 → CNT=3, sorted 5,5,7; DELETE 9 → ERR pulse, array unchanged, CNT=3.
- INSERT while FULL, or DELETE while empty → ERR pulses exactly 2 cycles after SEN, CNT unchanged, VAL still pulses.
- CLR asserted together with SEN INSERT mid-stream → CNT=0, all RANK reads return 255, no ERR; RST_N low mid-burst gives the same state plus RES=0 and VAL=0 immediately, without a clock.
- N=9 instance, INSERT 9 random values then 100 random REPLACEs with RANK=4 → RES matches a reference-model median on every VAL.
